mem_port_arbiter: RTL and testbench

- Shares one memory/peripheral request port (req/req_block/rw/add/data, answered by ready/done/valid/data) between N_PORTS requesters, e.g. port 0 = JTAG comm controller and port 1 = core debug unit.
- Each requester keeps its existing single-owner handshake: wait for ready, pulse req, wait for done, pulse clear.
- The arbiter offers ready round-robin, locks ownership from req to clear, and routes responses only to the owner.

---
 rtl/mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory request port between N_PORTS single-owner requesters.
// Define MEM_ARB_WATCHDOG_EN to add a request watchdog that force-completes a stalled owner.
module mem_port_arbiter #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned ADDR_W  = 27,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                        clock_i,
    input  logic                        resetn_i,
    input  logic [N_PORTS-1:0]          req_i,
    input  logic [N_PORTS-1:0]          req_block_i,
    input  logic [N_PORTS-1:0]          rw_i,
    input  logic [3*N_PORTS-1:0]        reqdev_i,
    input  logic [ADDR_W*N_PORTS-1:0]   add_i,
    input  logic [DATA_W*N_PORTS-1:0]   data_i,
    input  logic [N_PORTS-1:0]          clear_i,
    output logic [N_PORTS-1:0]          ready_o,
    output logic [N_PORTS-1:0]          done_o,
    output logic [N_PORTS-1:0]          valid_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        mem_req_o,
    output logic                        mem_req_block_o,
    output logic                        mem_rw_o,
    output logic [2:0]                  mem_reqdev_o,
    output logic [ADDR_W-1:0]           mem_add_o,
    output logic [DATA_W-1:0]           mem_data_o,
    output logic                        mem_clear_o,
    input  logic                        mem_ready_i,
    input  logic                        mem_done_i,
    input  logic                        mem_valid_i,
    input  logic [DATA_W-1:0]           mem_data_i,
    output logic [1:0]                  owner_o,
    output logic                        busy_o,
    output logic                        error_o
);

    localparam int unsigned IDX_W  = 2;
    localparam int unsigned BEAT_W = 5;
    localparam int unsigned WD_W   = 16;
    localparam logic [BEAT_W-1:0] BEAT_MAX = 5'd16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACTIVE  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    if (N_PORTS < 2 || N_PORTS > 4 || TIMEOUT < 2 || TIMEOUT > 65536) begin : g_param_check
        $error("mem_port_arbiter: illegal parameter set");
    end

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    offer_q, offer_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                error_q, error_d;
    logic                busy_q, busy_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_blk_q, mem_blk_d;
    logic                mem_rw_q, mem_rw_d;
    logic [2:0]          mem_dev_q, mem_dev_d;
    logic [ADDR_W-1:0]   mem_add_q, mem_add_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_clear_q, mem_clear_d;
    logic [N_PORTS-1:0]  done_q, done_d;
    logic [N_PORTS-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [IDX_W-1:0]    sel_idx_c;
    logic [N_PORTS-1:0]  sel_oh_c;
    logic [N_PORTS-1:0]  offer_oh_c;
    logic                sel_blk_c;
    logic                sel_rw_c;
    logic [2:0]          sel_dev_c;
    logic [ADDR_W-1:0]   sel_add_c;
    logic [DATA_W-1:0]   sel_data_c;
    logic                wd_fire_c;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_PORTS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // In IDLE the offered port is the candidate; otherwise the owner's lanes are forwarded.
    assign sel_idx_c  = (state_q == ST_IDLE) ? offer_q : owner_q;
    assign sel_oh_c   = N_PORTS'(1) << sel_idx_c;
    assign offer_oh_c = N_PORTS'(1) << offer_q;

    always_comb begin
        sel_blk_c  = 1'b0;
        sel_rw_c   = 1'b0;
        sel_dev_c  = '0;
        sel_add_c  = '0;
        sel_data_c = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (sel_idx_c == IDX_W'(k)) begin
                sel_blk_c  = req_block_i[k];
                sel_rw_c   = rw_i[k];
                sel_dev_c  = reqdev_i[k*3 +: 3];
                sel_add_c  = add_i[k*ADDR_W +: ADDR_W];
                sel_data_c = data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Ready is offered combinationally so a requester can answer within the offer cycle.
    assign ready_o = (resetn_i && state_q == ST_IDLE && mem_ready_i && !mem_done_i)
                     ? offer_oh_c : '0;

`ifdef MEM_ARB_WATCHDOG_EN
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_seen_q, wd_seen_d;

    always_comb begin
        wd_d      = wd_q;
        wd_seen_d = wd_seen_q;
        if (state_q != ST_ACTIVE) begin
            wd_d      = '0;
            wd_seen_d = 1'b0;
        end else begin
            if (mem_done_i) wd_seen_d = 1'b1;
            if (!wd_seen_q && !mem_done_i) wd_d = wd_q + WD_W'(1);
        end
    end

    assign wd_fire_c = (state_q == ST_ACTIVE) && !wd_seen_q && !mem_done_i &&
                       (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wd_q      <= '0;
            wd_seen_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            wd_seen_q <= wd_seen_d;
        end
    end
`else
    assign wd_fire_c = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        offer_d     = offer_q;
        owner_d     = owner_q;
        beat_d      = beat_q;
        error_d     = error_q;
        mem_req_d   = 1'b0;
        mem_blk_d   = mem_blk_q;
        mem_rw_d    = mem_rw_q;
        mem_dev_d   = mem_dev_q;
        mem_add_d   = mem_add_q;
        mem_wdata_d = mem_wdata_q;
        mem_clear_d = 1'b0;
        done_d      = '0;
        valid_d     = '0;
        rdata_d     = rdata_q;

        case (state_q)
            ST_IDLE: begin
                mem_blk_d = 1'b0;
                if ((req_i & ~offer_oh_c) != '0) error_d = 1'b1;
                if ((req_i & offer_oh_c) != '0) begin
                    owner_d     = offer_q;
                    state_d     = ST_ACTIVE;
                    beat_d      = '0;
                    mem_req_d   = 1'b1;
                    mem_blk_d   = sel_blk_c;
                    mem_rw_d    = sel_rw_c;
                    mem_dev_d   = sel_dev_c;
                    mem_add_d   = sel_add_c;
                    mem_wdata_d = sel_data_c;
                end else begin
                    offer_d = next_idx(offer_q);
                end
            end
            ST_ACTIVE: begin
                mem_blk_d   = sel_blk_c;
                mem_wdata_d = sel_data_c;
                done_d      = sel_oh_c & {N_PORTS{mem_done_i}};
                rdata_d     = mem_data_i;
                if (mem_valid_i) begin
                    if (beat_q == BEAT_MAX) begin
                        error_d = 1'b1;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        valid_d = sel_oh_c;
                    end
                end
                if (req_i != '0) error_d = 1'b1;
                if ((clear_i & ~sel_oh_c) != '0) error_d = 1'b1;
                if ((clear_i & sel_oh_c) != '0) begin
                    state_d     = ST_RELEASE;
                    mem_clear_d = 1'b1;
                    mem_blk_d   = 1'b0;
                    done_d      = '0;
                    valid_d     = '0;
                end else if (wd_fire_c) begin
                    // A stalled owner is completed with a forced done alongside the clear.
                    state_d     = ST_RELEASE;
                    mem_clear_d = 1'b1;
                    mem_blk_d   = 1'b0;
                    error_d     = 1'b1;
                    done_d      = sel_oh_c;
                    valid_d     = '0;
                end
            end
            ST_RELEASE: begin
                mem_blk_d = 1'b0;
                offer_d   = next_idx(owner_q);
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= ST_IDLE;
            offer_q     <= '0;
            owner_q     <= '0;
            beat_q      <= '0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_blk_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_dev_q   <= '0;
            mem_add_q   <= '0;
            mem_wdata_q <= '0;
            mem_clear_q <= 1'b0;
            done_q      <= '0;
            valid_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            offer_q     <= offer_d;
            owner_q     <= owner_d;
            beat_q      <= beat_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_blk_q   <= mem_blk_d;
            mem_rw_q    <= mem_rw_d;
            mem_dev_q   <= mem_dev_d;
            mem_add_q   <= mem_add_d;
            mem_wdata_q <= mem_wdata_d;
            mem_clear_q <= mem_clear_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign done_o          = done_q;
    assign valid_o         = valid_q;
    assign rdata_o         = rdata_q;
    assign mem_req_o       = mem_req_q;
    assign mem_req_block_o = mem_blk_q;
    assign mem_rw_o        = mem_rw_q;
    assign mem_reqdev_o    = mem_dev_q;
    assign mem_add_o       = mem_add_q;
    assign mem_data_o      = mem_wdata_q;
    assign mem_clear_o     = mem_clear_q;
    assign owner_o         = owner_q;
    assign busy_o          = busy_q;
    assign error_o         = error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with two requesters.
module tb_mem_port_arbiter;

    localparam int unsigned N_PORTS = 2;
    localparam int unsigned ADDR_W  = 27;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 8;

    logic                      clock_i = 1'b0;
    logic                      resetn_i;
    logic [N_PORTS-1:0]        req_i;
    logic [N_PORTS-1:0]        req_block_i;
    logic [N_PORTS-1:0]        rw_i;
    logic [3*N_PORTS-1:0]      reqdev_i;
    logic [ADDR_W*N_PORTS-1:0] add_i;
    logic [DATA_W*N_PORTS-1:0] data_i;
    logic [N_PORTS-1:0]        clear_i;
    logic [N_PORTS-1:0]        ready_o;
    logic [N_PORTS-1:0]        done_o;
    logic [N_PORTS-1:0]        valid_o;
    logic [DATA_W-1:0]         rdata_o;
    logic                      mem_req_o;
    logic                      mem_req_block_o;
    logic                      mem_rw_o;
    logic [2:0]                mem_reqdev_o;
    logic [ADDR_W-1:0]         mem_add_o;
    logic [DATA_W-1:0]         mem_data_o;
    logic                      mem_clear_o;
    logic                      mem_ready_i;
    logic                      mem_done_i;
    logic                      mem_valid_i;
    logic [DATA_W-1:0]         mem_data_i;
    logic [1:0]                owner_o;
    logic                      busy_o;
    logic                      error_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(
        .N_PORTS (N_PORTS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock_i         (clock_i),
        .resetn_i        (resetn_i),
        .req_i           (req_i),
        .req_block_i     (req_block_i),
        .rw_i            (rw_i),
        .reqdev_i        (reqdev_i),
        .add_i           (add_i),
        .data_i          (data_i),
        .clear_i         (clear_i),
        .ready_o         (ready_o),
        .done_o          (done_o),
        .valid_o         (valid_o),
        .rdata_o         (rdata_o),
        .mem_req_o       (mem_req_o),
        .mem_req_block_o (mem_req_block_o),
        .mem_rw_o        (mem_rw_o),
        .mem_reqdev_o    (mem_reqdev_o),
        .mem_add_o       (mem_add_o),
        .mem_data_o      (mem_data_o),
        .mem_clear_o     (mem_clear_o),
        .mem_ready_i     (mem_ready_i),
        .mem_done_i      (mem_done_i),
        .mem_valid_i     (mem_valid_i),
        .mem_data_i      (mem_data_i),
        .owner_o         (owner_o),
        .busy_o          (busy_o),
        .error_o         (error_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge; inputs change here, checks 1 unit later.
    task automatic cyc();
        @(posedge clock_i);
        #2;
    endtask

    task automatic drive_port(input int p, input logic rw, input logic blk,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        rw_i[p]                   = rw;
        req_block_i[p]            = blk;
        reqdev_i[p*3 +: 3]        = 3'(p + 1);
        add_i[p*ADDR_W +: ADDR_W] = a;
        data_i[p*DATA_W +: DATA_W] = d;
    endtask

    // Full single-word read by port p starting in an IDLE cycle where p is offered.
    task automatic single_read(input int p, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] rd, input logic [1:0] nxt_oh);
        logic [1:0] my_oh;
        my_oh = (p == 0) ? 2'b01 : 2'b10;
        #1 chk("sr_ready_offer", 64'(ready_o), 64'(my_oh));
        drive_port(p, 1'b0, 1'b0, a, 32'h0);
        req_i = my_oh;
        cyc();
        req_i = '0;
        mem_done_i = 1'b1;
        mem_data_i = rd;
        #1;
        chk("sr_mem_req", 64'(mem_req_o), 64'd1);
        chk("sr_mem_add", 64'(mem_add_o), 64'(a));
        chk("sr_mem_rw", 64'(mem_rw_o), 64'd0);
        chk("sr_reqdev", 64'(mem_reqdev_o), 64'(p + 1));
        chk("sr_owner", 64'(owner_o), 64'(p));
        chk("sr_busy", 64'(busy_o), 64'd1);
        chk("sr_ready_active", 64'(ready_o), 64'd0);
        cyc();
        clear_i = my_oh;
        #1;
        chk("sr_done", 64'(done_o), 64'(my_oh));
        chk("sr_rdata", 64'(rdata_o), 64'(rd));
        chk("sr_req_pulse", 64'(mem_req_o), 64'd0);
        cyc();
        clear_i = '0;
        mem_done_i = 1'b0;
        #1;
        chk("sr_clear", 64'(mem_clear_o), 64'd1);
        chk("sr_done_rel", 64'(done_o), 64'd0);
        chk("sr_ready_rel", 64'(ready_o), 64'd0);
        cyc();
        #1;
        chk("sr_clear_end", 64'(mem_clear_o), 64'd0);
        chk("sr_busy_end", 64'(busy_o), 64'd0);
        chk("sr_next_offer", 64'(ready_o), 64'(nxt_oh));
    endtask

    // Done/clear/release tail of a transaction, entered during an ACTIVE cycle.
    task automatic finish_txn(input logic [1:0] my_oh, input logic [1:0] nxt_oh);
        mem_done_i = 1'b1;
        cyc();
        clear_i = my_oh;
        #1 chk("ft_done", 64'(done_o), 64'(my_oh));
        cyc();
        clear_i = '0;
        mem_done_i = 1'b0;
        #1;
        chk("ft_clear", 64'(mem_clear_o), 64'd1);
        chk("ft_done_rel", 64'(done_o), 64'd0);
        cyc();
        #1;
        chk("ft_clear_end", 64'(mem_clear_o), 64'd0);
        chk("ft_next_offer", 64'(ready_o), 64'(nxt_oh));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [1:0] nxt;
        int         p;

        resetn_i    = 1'b0;
        req_i       = '0;
        req_block_i = '0;
        rw_i        = '0;
        reqdev_i    = '0;
        add_i       = '0;
        data_i      = '0;
        clear_i     = '0;
        mem_ready_i = 1'b1;
        mem_done_i  = 1'b0;
        mem_valid_i = 1'b0;
        mem_data_i  = '0;

        // Reset state
        cyc();
        #1;
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_owner", 64'(owner_o), 64'd0);
        chk("rst_error", 64'(error_o), 64'd0);
        chk("rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("rst_mem_clear", 64'(mem_clear_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        cyc();
        resetn_i = 1'b1;

        // Single read by port 0
        single_read(0, 27'h0000100, 32'hDEADBEEF, 2'b10);

        // Back-to-back contention: grants alternate starting from port 1
        for (int i = 0; i < 8; i++) begin
            p   = (i % 2 == 0) ? 1 : 0;
            nxt = (p == 0) ? 2'b10 : 2'b01;
            single_read(p, 27'h0000200 + 27'(i), 32'hA0000000 + 32'(i), nxt);
        end
        chk("rr_no_error", 64'(error_o), 64'd0);

        // Block write by port 1, 16 words delayed one cycle
        drive_port(1, 1'b1, 1'b1, 27'h0000300, 32'h0);
        req_i = 2'b10;
        cyc();
        req_i = '0;
        data_i[DATA_W +: DATA_W] = 32'h1;
        #1;
        chk("bw_mem_req", 64'(mem_req_o), 64'd1);
        chk("bw_block", 64'(mem_req_block_o), 64'd1);
        chk("bw_rw", 64'(mem_rw_o), 64'd1);
        chk("bw_word0", 64'(mem_data_o), 64'd0);
        for (int k = 1; k < 16; k++) begin
            cyc();
            data_i[DATA_W +: DATA_W] = 32'(k + 1);
            #1;
            chk("bw_word", 64'(mem_data_o), 64'(k));
            chk("bw_block_hold", 64'(mem_req_block_o), 64'd1);
        end
        req_block_i = '0;
        finish_txn(2'b10, 2'b01);
        chk("bw_no_error", 64'(error_o), 64'd0);

        // Block read by port 0: 16 beats, then an excess 17th beat
        drive_port(0, 1'b0, 1'b1, 27'h0000400, 32'h0);
        req_i = 2'b01;
        cyc();
        req_i = '0;
        mem_valid_i = 1'b1;
        mem_data_i  = 32'h10;
        #1;
        chk("br_mem_req", 64'(mem_req_o), 64'd1);
        chk("br_block", 64'(mem_req_block_o), 64'd1);
        for (int k = 0; k < 16; k++) begin
            cyc();
            mem_data_i = 32'h11 + 32'(k);
            #1;
            chk("br_valid", 64'(valid_o), 64'd1);
            chk("br_rdata", 64'(rdata_o), 64'h10 + 64'(k));
            chk("br_error_low", 64'(error_o), 64'd0);
        end
        cyc();
        mem_valid_i = 1'b0;
        #1;
        chk("br_17th_valid", 64'(valid_o), 64'd0);
        chk("br_17th_error", 64'(error_o), 64'd1);
        req_block_i = '0;
        finish_txn(2'b01, 2'b10);

        // Reset clears the sticky error; ready follows mem_ready while offer rotates
        resetn_i = 1'b0;
        #1;
        chk("rst2_error", 64'(error_o), 64'd0);
        chk("rst2_busy", 64'(busy_o), 64'd0);
        cyc();
        resetn_i    = 1'b1;
        mem_ready_i = 1'b0;
        #1 chk("ready_drop", 64'(ready_o), 64'd0);
        cyc();
        mem_ready_i = 1'b1;
        #1 chk("offer_rotated", 64'(ready_o), 64'd2);

        // Request on a non-offered port is ignored and flagged
        req_i = 2'b01;
        cyc();
        req_i = '0;
        #1;
        chk("nonoffer_error", 64'(error_o), 64'd1);
        chk("nonoffer_busy", 64'(busy_o), 64'd0);
        chk("nonoffer_mem_req", 64'(mem_req_o), 64'd0);
        chk("nonoffer_rotate", 64'(ready_o), 64'd1);

        // Clear from a non-owner in ACTIVE is ignored and flagged
        resetn_i = 1'b0;
        cyc();
        resetn_i = 1'b1;
        req_i = 2'b01;
        cyc();
        req_i   = '0;
        clear_i = 2'b10;
        #1;
        chk("nc_busy", 64'(busy_o), 64'd1);
        chk("nc_error_pre", 64'(error_o), 64'd0);
        cyc();
        clear_i    = '0;
        mem_done_i = 1'b1;
        #1;
        chk("nc_error", 64'(error_o), 64'd1);
        chk("nc_still_busy", 64'(busy_o), 64'd1);
        chk("nc_no_clear", 64'(mem_clear_o), 64'd0);
        cyc();
        #1 chk("nc_done_owner", 64'(done_o), 64'd1);

        // Asynchronous reset mid-ACTIVE aborts with no downstream clear
        resetn_i = 1'b0;
        #1;
        chk("ar_done", 64'(done_o), 64'd0);
        chk("ar_busy", 64'(busy_o), 64'd0);
        chk("ar_error", 64'(error_o), 64'd0);
        chk("ar_ready", 64'(ready_o), 64'd0);
        chk("ar_owner", 64'(owner_o), 64'd0);
        cyc();
        mem_done_i = 1'b0;
        #1 chk("ar_no_clear", 64'(mem_clear_o), 64'd0);
        resetn_i = 1'b1;

        // Simultaneous requests: offered port 0 wins, port 1 flags an error
        req_i = 2'b11;
        cyc();
        req_i = '0;
        #1;
        chk("sim_owner", 64'(owner_o), 64'd0);
        chk("sim_mem_req", 64'(mem_req_o), 64'd1);
        chk("sim_error", 64'(error_o), 64'd1);
        finish_txn(2'b01, 2'b10);

`ifdef MEM_ARB_WATCHDOG_EN
        // Withheld done is force-completed after TIMEOUT active cycles
        resetn_i = 1'b0;
        cyc();
        resetn_i = 1'b1;
        req_i = 2'b01;
        cyc();
        req_i = '0;
        #1 chk("wd_mem_req", 64'(mem_req_o), 64'd1);
        repeat (7) cyc();
        #1;
        chk("wd_not_yet", 64'(mem_clear_o), 64'd0);
        chk("wd_err_pre", 64'(error_o), 64'd0);
        cyc();
        #1;
        chk("wd_forced_done", 64'(done_o), 64'd1);
        chk("wd_clear", 64'(mem_clear_o), 64'd1);
        chk("wd_error", 64'(error_o), 64'd1);
        cyc();
        #1;
        chk("wd_done_end", 64'(done_o), 64'd0);
        chk("wd_next_offer", 64'(ready_o), 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
